// File: rtl/srx_pkg.sv
// rtl/srx_pkg.sv - shared types, defaults and width helper for the serial receiver
package srx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } asm_state_e;

    // Bit counter width; never narrower than one bit even for the smallest word.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/srx_hold_reg.sv
// rtl/srx_hold_reg.sv - one-entry valid/ready holding register with sticky overrun
module srx_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_done,
    input  logic             par_ready,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             drop_word;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        drop_word = 1'b0;

        if (word_done) begin
            // A word arriving while the consumer drains the old one takes its slot.
            if (!valid_q || par_ready) begin
                data_d  = word_in;
                valid_d = 1'b1;
            end else begin
                drop_word = 1'b1;
            end
        end else if (valid_q && par_ready) begin
            valid_d = 1'b0;
        end

        overrun_d = drop_word | (overrun_q & ~clear_overrun);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign par_out   = data_q;
    assign par_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - serial-in parallel-out word assembler with handshake output
module serial_to_parallel_rx
    import srx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    input  logic             clear_overrun,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    asm_state_e       state_q, state_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_shifted;
    logic             word_done;

    always_comb begin
        sr_base = frame_start ? '0 : sr_q;
        if (LSB_FIRST) begin
            sr_shifted = {ser_in, sr_base[WIDTH-1:1]};
        end else begin
            sr_shifted = {sr_base[WIDTH-2:0], ser_in};
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        sr_d        = sr_q;
        word_done   = 1'b0;

        if (ser_valid) begin
            sr_d = sr_shifted;
            if (frame_start) begin
                // Realignment beats completion: the current bit opens a new word.
                state_d     = ASSEMBLE;
                bit_count_d = CW'(1);
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d     = ASSEMBLE;
                        bit_count_d = CW'(1);
                    end
                    ASSEMBLE: begin
                        if (bit_count_q == LAST_BIT) begin
                            word_done   = 1'b1;
                            state_d     = IDLE;
                            bit_count_d = '0;
                        end else begin
                            bit_count_d = bit_count_q + CW'(1);
                        end
                    end
                    default: begin
                        state_d     = IDLE;
                        bit_count_d = '0;
                    end
                endcase
            end
        end else if (frame_start) begin
            state_d     = IDLE;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            sr_q        <= '0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            sr_q        <= sr_d;
        end
    end

    assign bit_count = bit_count_q;

    srx_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk           (clk),
        .reset_n       (reset_n),
        .word_in       (sr_shifted),
        .word_done     (word_done),
        .par_ready     (par_ready),
        .clear_overrun (clear_overrun),
        .par_out       (par_out),
        .par_valid     (par_valid),
        .overrun       (overrun)
    );

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - directed vector bench for serial_to_parallel_rx
module tb_serial_to_parallel_rx;

    logic       clk;
    logic       reset_n;
    logic       ser_in;
    logic       ser_valid;
    logic       frame_start;
    logic       par_ready;
    logic       clear_overrun;

    logic [7:0] par_out_l, par_out_m;
    logic       par_valid_l, par_valid_m;
    logic       overrun_l, overrun_m;
    logic [2:0] bit_count_l, bit_count_m;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] seq;       // seq[7] is sent first
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
        bit         gaps;
    } vec_t;

    vec_t tbl[6];

    serial_to_parallel_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk           (clk),
        .reset_n       (reset_n),
        .ser_in        (ser_in),
        .ser_valid     (ser_valid),
        .frame_start   (frame_start),
        .par_out       (par_out_l),
        .par_valid     (par_valid_l),
        .par_ready     (par_ready),
        .overrun       (overrun_l),
        .clear_overrun (clear_overrun),
        .bit_count     (bit_count_l)
    );

    serial_to_parallel_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk           (clk),
        .reset_n       (reset_n),
        .ser_in        (ser_in),
        .ser_valid     (ser_valid),
        .frame_start   (frame_start),
        .par_out       (par_out_m),
        .par_valid     (par_valid_m),
        .par_ready     (par_ready),
        .overrun       (overrun_m),
        .clear_overrun (clear_overrun),
        .bit_count     (bit_count_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic fs, input logic b);
        frame_start = fs;
        ser_valid   = 1'b1;
        ser_in      = b;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        ser_valid   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] seq, input bit gaps, input logic rdy,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    ser_valid = 1'b0;
                    ser_in    = 1'($urandom);
                    par_ready = rdy;
                    @(posedge clk);
                    #1;
                    chk("gap_hold_count", 16'(bit_count_l), 16'(i));
                end
            end
            frame_start   = 1'b0;
            ser_valid     = 1'b1;
            ser_in        = seq[7-i];
            par_ready     = (i == 7) ? rdy_last : rdy;
            clear_overrun = (i == 7) ? clr_last : 1'b0;
            @(posedge clk);
            #1;
            chk("bit_count", 16'(bit_count_l), 16'((i + 1) % 8));
        end
        ser_valid     = 1'b0;
        clear_overrun = 1'b0;
        par_ready     = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        ser_in        = 1'b0;
        ser_valid     = 1'b0;
        frame_start   = 1'b0;
        par_ready     = 1'b0;
        clear_overrun = 1'b0;

        tbl[0] = '{8'b10100101, 8'hA5, 8'hA5, 1'b0};
        tbl[1] = '{8'b11000000, 8'h03, 8'hC0, 1'b0};
        tbl[2] = '{8'b00111100, 8'h3C, 8'h3C, 1'b0};
        tbl[3] = '{8'b10000000, 8'h01, 8'h80, 1'b0};
        tbl[4] = '{8'b11110000, 8'h0F, 8'hF0, 1'b1};
        tbl[5] = '{8'b01101001, 8'h96, 8'h69, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_par_out", 16'(par_out_l), 16'h00);
        chk("rst_par_valid", 16'(par_valid_l), 16'h0);
        chk("rst_overrun", 16'(overrun_l), 16'h0);
        chk("rst_bit_count", 16'(bit_count_l), 16'h0);
        reset_n = 1'b1;
        idle();

        for (int k = 0; k < 6; k++) begin
            send_word(tbl[k].seq, tbl[k].gaps, 1'b1, 1'b1, 1'b0);
            chk("tbl_lsb_out", 16'(par_out_l), 16'(tbl[k].exp_lsb));
            chk("tbl_msb_out", 16'(par_out_m), 16'(tbl[k].exp_msb));
            chk("tbl_valid", 16'(par_valid_l), 16'h1);
            chk("tbl_msb_valid", 16'(par_valid_m), 16'h1);
            chk("tbl_count_wrap", 16'(bit_count_m), 16'h0);
            par_ready = 1'b1;
            idle();
            chk("tbl_valid_one_cycle", 16'(par_valid_l), 16'h0);
            par_ready = 1'b0;
        end

        // backpressure: second word dropped, overrun sticky, set beats clear
        send_word(8'b00111100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_first_out", 16'(par_out_l), 16'h3C);
        chk("bp_first_ovr", 16'(overrun_l), 16'h0);
        send_word(8'b01011010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_out", 16'(par_out_l), 16'h3C);
        chk("bp_hold_valid", 16'(par_valid_l), 16'h1);
        chk("bp_overrun", 16'(overrun_l), 16'h1);
        chk("bp_msb_overrun", 16'(overrun_m), 16'h1);
        clear_overrun = 1'b1;
        idle();
        clear_overrun = 1'b0;
        chk("bp_cleared", 16'(overrun_l), 16'h0);
        chk("bp_out_after_clr", 16'(par_out_l), 16'h3C);
        send_word(8'b11111111, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_set_beats_clear", 16'(overrun_l), 16'h1);
        chk("bp_out_still", 16'(par_out_l), 16'h3C);
        clear_overrun = 1'b1;
        idle();
        clear_overrun = 1'b0;
        chk("bp_cleared2", 16'(overrun_l), 16'h0);
        par_ready = 1'b1;
        idle();
        chk("bp_drain", 16'(par_valid_l), 16'h0);
        par_ready = 1'b0;

        // completion while FULL with ready on the same cycle
        send_word(8'b10001000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_first", 16'(par_out_l), 16'h11);
        send_word(8'b01000100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sim_valid", 16'(par_valid_l), 16'h1);
        chk("sim_out", 16'(par_out_l), 16'h22);
        chk("sim_no_ovr", 16'(overrun_l), 16'h0);
        par_ready = 1'b1;
        idle();
        chk("sim_drain", 16'(par_valid_l), 16'h0);

        // realignment
        repeat (5) bit_in(1'b0, 1'b1);
        chk("ra_partial", 16'(bit_count_l), 16'h5);
        bit_in(1'b1, 1'b1);
        chk("ra_restart_cnt", 16'(bit_count_l), 16'h1);
        repeat (7) bit_in(1'b0, 1'b0);
        chk("ra_lsb_out", 16'(par_out_l), 16'h01);
        chk("ra_msb_out", 16'(par_out_m), 16'h80);
        chk("ra_valid", 16'(par_valid_l), 16'h1);
        idle();
        repeat (3) bit_in(1'b0, 1'b1);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        chk("ra_fs_alone_cnt", 16'(bit_count_l), 16'h0);
        chk("ra_fs_alone_valid", 16'(par_valid_l), 16'h0);
        repeat (7) bit_in(1'b0, 1'b1);
        chk("ra_seven", 16'(bit_count_l), 16'h7);
        bit_in(1'b1, 1'b0);
        chk("ra_fs_wins_valid", 16'(par_valid_l), 16'h0);
        chk("ra_fs_wins_cnt", 16'(bit_count_l), 16'h1);
        bit_in(1'b0, 1'b1);
        repeat (6) bit_in(1'b0, 1'b0);
        chk("ra2_lsb_out", 16'(par_out_l), 16'h02);
        chk("ra2_msb_out", 16'(par_out_m), 16'h40);
        idle();
        par_ready = 1'b0;

        // reset mid-word
        repeat (4) bit_in(1'b0, 1'b1);
        chk("rs_mid_cnt", 16'(bit_count_l), 16'h4);
        reset_n = 1'b0;
        #1;
        chk("rs_mid_cnt0", 16'(bit_count_l), 16'h0);
        chk("rs_mid_out0", 16'(par_out_l), 16'h00);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // reset while FULL with overrun pending
        send_word(8'b10100101, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'b11110000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rs_full_ovr", 16'(overrun_l), 16'h1);
        reset_n = 1'b0;
        #1;
        chk("rs_full_out0", 16'(par_out_l), 16'h00);
        chk("rs_full_valid0", 16'(par_valid_l), 16'h0);
        chk("rs_full_ovr0", 16'(overrun_l), 16'h0);
        chk("rs_full_cnt0", 16'(bit_count_l), 16'h0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'b11000000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rs_after_lsb", 16'(par_out_l), 16'h03);
        chk("rs_after_msb", 16'(par_out_m), 16'hC0);
        chk("rs_after_valid", 16'(par_valid_l), 16'h1);
        chk("rs_after_ovr", 16'(overrun_l), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
